// File: rtl/lfsr_bank_pkg.sv
// Shared register map and CTRL bit positions for the LFSR bank.
package lfsr_bank_pkg;

  localparam logic [1:0] OFF_CTRL  = 2'd0;
  localparam logic [1:0] OFF_SEED  = 2'd1;
  localparam logic [1:0] OFF_STATE = 2'd2;
  localparam logic [1:0] OFF_TAPS  = 2'd3;

  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_STEP = 1;
  localparam int unsigned CTRL_LOCK = 7;

endpackage

// File: rtl/lfsr_channel.sv
// One programmable Fibonacci LFSR with seed, taps, enable/step and lock-up recovery.
module lfsr_channel
  import lfsr_bank_pkg::*;
#(
  parameter int unsigned      WIDTH        = 8,
  parameter logic [WIDTH-1:0] DEFAULT_TAPS = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_ctrl,
  input  logic             wr_seed,
  input  logic             wr_taps,
  input  logic [WIDTH-1:0] data_wr,
  output logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] taps,
  output logic [WIDTH-1:0] ctrl_rd_c,
  output logic             lfsr_out
);

  logic             en;
  logic             lock;
  logic             shift_due_c;
  logic             lockup_c;
  logic [WIDTH-1:0] state_nxt_c;
  logic [31:0]      ctrl_wide_c;

  // Next state: a SEED write overrides any shift; an all-zero state reloads from seed.
  always_comb begin
    shift_due_c = en | (wr_ctrl & data_wr[CTRL_STEP]);
    lockup_c    = shift_due_c & ~wr_seed & (state == '0);
    state_nxt_c = state;
    if (wr_seed) begin
      state_nxt_c = data_wr;
    end else if (shift_due_c) begin
      if (state == '0) begin
        state_nxt_c = (seed == '0) ? WIDTH'(1) : seed;
      end else begin
        state_nxt_c = {state[WIDTH-2:0], ^(state & taps)};
      end
    end
  end

  // Channel registers; a CTRL write clears LOCK unless a lock-up happens on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= DEFAULT_SEED;
      seed  <= DEFAULT_SEED;
      taps  <= DEFAULT_TAPS;
      en    <= 1'b0;
      lock  <= 1'b0;
    end else begin
      state <= state_nxt_c;
      if (wr_seed) seed <= data_wr;
      if (wr_taps) taps <= data_wr;
      if (wr_ctrl) en <= data_wr[CTRL_EN];
      lock <= (lock & ~wr_ctrl) | lockup_c;
    end
  end

  // CTRL read value built wide so LOCK drops out cleanly on narrow buses.
  always_comb begin
    ctrl_wide_c = (32'(lock) << CTRL_LOCK) | 32'(en);
    ctrl_rd_c   = ctrl_wide_c[WIDTH-1:0];
  end

  assign lfsr_out = state[WIDTH-1];

endmodule

// File: rtl/lfsr_bank.sv
// Bank of programmable LFSR channels behind the simple ce/rd/wr CPU bus.
module lfsr_bank
  import lfsr_bank_pkg::*;
#(
  parameter int unsigned      CHANNELS     = 4,
  parameter int unsigned      WIDTH        = 8,
  parameter int unsigned      ADDR_W       = 8,
  parameter logic [WIDTH-1:0] DEFAULT_TAPS = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ce,
  input  logic                rd,
  input  logic                wr,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [WIDTH-1:0]    data_wr,
  output logic [WIDTH-1:0]    data_rd,
  output logic                rd_valid,
  output logic [CHANNELS-1:0] lfsr_out
);

  localparam int unsigned CH_W = ADDR_W - 2;

  logic [CH_W-1:0]                ch_c;
  logic [1:0]                     off_c;
  logic                           wr_en_c;
  logic                           rd_go_c;
  logic [CHANNELS-1:0]            wr_ctrl_c;
  logic [CHANNELS-1:0]            wr_seed_c;
  logic [CHANNELS-1:0]            wr_taps_c;
  logic [CHANNELS-1:0][WIDTH-1:0] state_a;
  logic [CHANNELS-1:0][WIDTH-1:0] seed_a;
  logic [CHANNELS-1:0][WIDTH-1:0] taps_a;
  logic [CHANNELS-1:0][WIDTH-1:0] ctrl_a;
  logic [WIDTH-1:0]               rd_mux_c;

  assign ch_c    = addr[ADDR_W-1:2];
  assign off_c   = addr[1:0];
  assign wr_en_c = ce & wr;
  assign rd_go_c = ce & rd & ~wr;

  // Per-channel write enables; unmapped channels match nothing.
  always_comb begin
    wr_ctrl_c = '0;
    wr_seed_c = '0;
    wr_taps_c = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (wr_en_c && (ch_c == CH_W'(i))) begin
        wr_ctrl_c[i] = (off_c == OFF_CTRL);
        wr_seed_c[i] = (off_c == OFF_SEED);
        wr_taps_c[i] = (off_c == OFF_TAPS);
      end
    end
  end

  // Read-back mux; unmapped channels read as zero.
  always_comb begin
    rd_mux_c = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_c == CH_W'(i)) begin
        if (off_c == OFF_CTRL)  rd_mux_c = ctrl_a[i];
        if (off_c == OFF_SEED)  rd_mux_c = seed_a[i];
        if (off_c == OFF_STATE) rd_mux_c = state_a[i];
        if (off_c == OFF_TAPS)  rd_mux_c = taps_a[i];
      end
    end
  end

  // Registered read response; data_rd holds between reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_rd  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_go_c;
      if (rd_go_c) data_rd <= rd_mux_c;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    lfsr_channel #(
      .WIDTH        (WIDTH),
      .DEFAULT_TAPS (DEFAULT_TAPS),
      .DEFAULT_SEED (DEFAULT_SEED)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .wr_ctrl   (wr_ctrl_c[g]),
      .wr_seed   (wr_seed_c[g]),
      .wr_taps   (wr_taps_c[g]),
      .data_wr   (data_wr),
      .state     (state_a[g]),
      .seed      (seed_a[g]),
      .taps      (taps_a[g]),
      .ctrl_rd_c (ctrl_a[g]),
      .lfsr_out  (lfsr_out[g])
    );
  end

endmodule

// File: tb/tb_lfsr_bank.sv
// Directed bench for lfsr_bank with a read-response scoreboard.
module tb_lfsr_bank;

  logic       clk;
  logic       reset;
  logic       ce;
  logic       rd;
  logic       wr;
  logic [7:0] addr;
  logic [7:0] data_wr;
  logic [7:0] data_rd;
  logic       rd_valid;
  logic [3:0] lfsr_out;

  int errors;
  int checks;
  logic [7:0] sb_q[$];
  string      tag_q[$];

  lfsr_bank dut (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .rd       (rd),
    .wr       (wr),
    .addr     (addr),
    .data_wr  (data_wr),
    .data_rd  (data_rd),
    .rd_valid (rd_valid),
    .lfsr_out (lfsr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference Fibonacci LFSR: n shifts with the given taps.
  function automatic logic [7:0] lfsr_adv(input logic [7:0] s, input logic [7:0] t, input int n);
    logic [7:0] r;
    r = s;
    for (int k = 0; k < n; k++) r = {r[6:0], ^(r & t)};
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end at a falling edge.
  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    ce = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; data_wr = d;
    @(negedge clk);
    ce = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [7:0] exp, input string tag);
    logic [7:0] e;
    string      t;
    ce = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
    sb_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    ce = 1'b0; rd = 1'b0;
    check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      check(t, 32'(data_rd), 32'(e));
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    reset = 1'b0; ce = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; data_wr = '0;
    repeat (2) @(negedge clk);
    check("rst_data_rd", 32'(data_rd), 32'h0);
    check("rst_rd_valid", 32'(rd_valid), 32'h0);
    check("rst_lfsr_out", 32'(lfsr_out), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // 1: reset contents of ch0, response timing and hold
    bus_read(8'h02, 8'h01, "t1_state");
    bus_read(8'h00, 8'h00, "t1_ctrl");
    bus_read(8'h03, 8'hB8, "t1_taps");
    @(negedge clk);
    check("t1_valid_drop", 32'(rd_valid), 32'h0);
    check("t1_data_hold", 32'(data_rd), 32'hB8);

    // 2: single steps on ch0
    bus_write(8'h00, 8'h02);
    bus_read(8'h02, 8'h02, "t2_step1");
    bus_write(8'h00, 8'h02);
    bus_read(8'h02, 8'h04, "t2_step2");
    bus_write(8'h00, 8'h02);
    bus_read(8'h02, 8'h08, "t2_step3");
    bus_read(8'h00, 8'h00, "t2_ctrl_step_reads0");

    // 3: ch1 seed, step with feedback, full period
    bus_write(8'h05, 8'h80);
    check("t3_lfsr_out1", 32'(lfsr_out[1]), 32'h1);
    bus_read(8'h06, 8'h80, "t3_seed_state");
    bus_read(8'h05, 8'h80, "t3_seed_reg");
    bus_write(8'h04, 8'h02);
    bus_read(8'h06, 8'h01, "t3_step_fb");
    bus_write(8'h04, 8'h01);
    repeat (254) @(negedge clk);
    bus_write(8'h04, 8'h00);
    bus_read(8'h06, lfsr_adv(8'h01, 8'hB8, 255), "t3_period_model");
    bus_read(8'h06, 8'h01, "t3_period");

    // 4: lock-up recovery on ch2
    bus_write(8'h08, 8'h01);
    bus_write(8'h09, 8'h00);
    bus_read(8'h0A, 8'h00, "t4_zero_pre_edge");
    bus_read(8'h0A, 8'h01, "t4_reload");
    bus_read(8'h08, 8'h81, "t4_lock_set");
    bus_write(8'h08, 8'h01);
    bus_read(8'h08, 8'h01, "t4_lock_clr");

    // 5: unmapped access, simultaneous rd+wr
    bus_read(8'h40, 8'h00, "t5_unmapped");
    bus_write(8'h41, 8'h55);
    bus_read(8'h01, 8'h01, "t5_unmapped_wr_ignored");
    ce = 1'b1; rd = 1'b1; wr = 1'b1; addr = 8'h03; data_wr = 8'h8E;
    @(negedge clk);
    ce = 1'b0; rd = 1'b0; wr = 1'b0;
    check("t5_rdwr_no_valid", 32'(rd_valid), 32'h0);
    bus_read(8'h03, 8'h8E, "t5_taps_written");

    // 6: reset mid-run with a read in flight on ch3
    bus_write(8'h0C, 8'h01);
    repeat (10) @(negedge clk);
    ce = 1'b1; rd = 1'b1; addr = 8'h0E;
    reset = 1'b0;
    #1;
    check("t6_rst_data_rd", 32'(data_rd), 32'h0);
    check("t6_rst_rd_valid", 32'(rd_valid), 32'h0);
    @(negedge clk);
    check("t6_rst_lfsr_out", 32'(lfsr_out), 32'h0);
    check("t6_rst_valid_held", 32'(rd_valid), 32'h0);
    ce = 1'b0; rd = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("t6_no_late_valid", 32'(rd_valid), 32'h0);
    bus_read(8'h0E, 8'h01, "t6_ch3_state");
    bus_read(8'h0C, 8'h00, "t6_ch3_ctrl");
    bus_read(8'h03, 8'hB8, "t6_ch0_taps");
    check("t6_sb_drained", 32'(sb_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
